// File: rtl/dm_wait_responder.sv
// rtl/dm_wait_responder.sv - memory-side responder for the CPU data request/wait port with internal word SRAM
// Optional range checking and dm_err_o port enabled by defining DM_RESP_ADDR_CHECK_EN.
module dm_wait_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_request_i,
    input  logic [3:0]  dm_bit_write_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_din_i,
    output logic        dm_wait_o,
    output logic [31:0] dm_dout_o
`ifdef DM_RESP_ADDR_CHECK_EN
   ,output logic        dm_err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // BUSY covers the wait cycles after the first, so it is loaded with LATENCY-2.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          commit;
    logic          is_read;
    logic          in_range;
    logic          unused_addr_bits;

    assign idx              = dm_addr_i[AW+1:2];
    assign unused_addr_bits = ^{dm_addr_i[31:AW+2], dm_addr_i[1:0]};
    assign is_read          = (dm_bit_write_i == 4'hF);

`ifdef DM_RESP_ADDR_CHECK_EN
    assign in_range = ({32'd0, dm_addr_i} < (64'(DEPTH_WORDS) * 64'd4));
`else
    assign in_range = 1'b1;
`endif

    assign dm_wait_o = dm_request_i & (state != S_DONE) & ~rst;

    // The access takes effect on the edge that enters DONE; reset discards it.
    assign commit = ~rst & dm_request_i &
                    (((state == S_IDLE) && (LATENCY == 1)) ||
                     ((state == S_BUSY) && (cnt == 4'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            dm_dout_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dm_request_i) begin
                        if (commit) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (!dm_request_i) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (commit && is_read) begin
                dm_dout_o <= in_range ? mem[idx] : 32'hDEAD_BEEF;
            end
        end
    end

`ifdef DM_RESP_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_err_o <= 1'b0;
        end else begin
            dm_err_o <= commit & ~in_range;
        end
    end
`endif

    // Array has no reset; only enabled byte lanes of an in-range write are updated.
    always_ff @(posedge clk) begin
        if (commit && !is_read && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (!dm_bit_write_i[n]) begin
                    mem[idx][8*n +: 8] <= dm_din_i[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_wait_responder.sv
// tb/tb_dm_wait_responder.sv - scoreboard bench for dm_wait_responder (honours DM_RESP_ADDR_CHECK_EN)
module tb_dm_wait_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [3:0]  bw;
    logic [31:0] addr;
    logic [31:0] din;
    logic        wait_s;
    logic [31:0] dout;
    logic        err;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] last_rd = 32'h0;
    int          errors  = 0;
    int          checks  = 0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    dm_wait_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dm_request_i(req),
        .dm_bit_write_i(bw),
        .dm_addr_i(addr),
        .dm_din_i(din),
        .dm_wait_o(wait_s),
        .dm_dout_o(dout)
`ifdef DM_RESP_ADDR_CHECK_EN
       ,.dm_err_o(err)
`endif
    );

`ifndef DM_RESP_ADDR_CHECK_EN
    assign err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle with request still high.
    task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_t        e;
        logic        oor;
        logic [31:0] cur;
        int          w;
        int          n;
        w = int'((a >> 2) % DEPTH);
`ifdef DM_RESP_ADDR_CHECK_EN
        oor = (a >= 32'(4 * DEPTH));
`else
        oor = 1'b0;
`endif
        if (s == 4'hF) begin
            if (oor) last_rd = 32'hDEAD_BEEF;
            else     last_rd = model.exists(w) ? model[w] : 32'h0;
        end else if (!oor) begin
            cur = model.exists(w) ? model[w] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (!s[b]) cur[8*b +: 8] = d[8*b +: 8];
            model[w] = cur;
        end
        e.dout = last_rd;
        e.err  = oor;
        sb.push_back(e);
        req  = 1'b1;
        addr = a;
        bw   = s;
        din  = d;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (!wait_s) break;
            n++;
        end
        chk("access_bound", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        bw  = 4'hF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // DONE is the only cycle where a live request sees wait low.
    always @(negedge clk) begin
        exp_t e;
        if (rst || !req) begin
            wait_cnt <= 0;
        end else if (wait_s) begin
            wait_cnt <= wait_cnt + 1;
            chk("err_outside_done", 32'(err), 32'd0);
        end else begin
            wait_cnt <= 0;
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wait_cycles", 32'(wait_cnt), 32'(LAT));
                chk("dout", dout, e.dout);
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: still running, required finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 1'b1;
        bw   = 4'hF;
        addr = 32'h0;
        din  = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wait", 32'(wait_s), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout, 32'h0);
        chk("idle_wait", 32'(wait_s), 32'd0);
        @(posedge clk);
        #1;

        access(32'h40, 4'h0, 32'h1234_5678);
        idle(1);
        access(32'h40, 4'hF, 32'h0);
        idle(1);

        access(32'h40, 4'h0, 32'hAABB_CCDD);
        access(32'h40, 4'b1010, 32'h1122_3344);
        access(32'h40, 4'hF, 32'h0);
        idle(1);

        access(32'h0, 4'h0, 32'h0000_0A0A);
        access(32'h4, 4'h0, 32'h0000_0B0B);
        access(32'h8, 4'h0, 32'h0000_0C0C);
        access(32'h0, 4'hF, 32'h0);
        access(32'h4, 4'hF, 32'h0);
        access(32'h8, 4'hF, 32'h0);
        idle(2);

        // Abort: request dropped while BUSY must not write.
        req  = 1'b1;
        addr = 32'h40;
        bw   = 4'h0;
        din  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("abort_wait_hi", 32'(wait_s), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk("abort_wait_lo", 32'(wait_s), 32'd0);
        @(posedge clk);
        #1;
        access(32'h40, 4'hF, 32'h0);
        idle(1);

        // Reset on the would-be commit edge discards the write.
        req  = 1'b1;
        addr = 32'h8;
        bw   = 4'h0;
        din  = 32'h5555_5555;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("rst_mid_dout", dout, 32'h0);
        last_rd = 32'h0;
        @(posedge clk);
        #1;
        access(32'h8, 4'hF, 32'h0);
        idle(1);

        // Range check (or aliasing onto word 0 when the check is absent).
        access(32'h0, 4'h0, 32'h0BAD_F00D);
        access(32'h1000, 4'hF, 32'h0);
        idle(1);
        access(32'h1000, 4'h0, 32'h7777_7777);
        access(32'h0, 4'hF, 32'h0);
        idle(1);

        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = 32'($urandom_range(0, 3)) << 2;
            s = (k % 3 == 2) ? 4'hF : 4'($urandom_range(0, 14));
            access(a, s, $urandom);
        end
        idle(2);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
